ring_counter_gen: RTL and testbench
===================================

# ring_counter_gen

Parametrised shift-ring sequencer that generalises the fixed 4-bit one-hot ring counter. It adds configurable width, two sequence modes (one-hot ring and twisted-ring/Johnson), direction control, count enable, parallel load, a position index, a wrap pulse and a legality flag. It drives phase-select and strobe-rotation logic elsewhere in the design from a single clock domain.

## Interface
- `WIDTH`, default 4: ring length in bits; legal range 2..32.
- `POS_W`, default `$clog2(2*WIDTH)`: width of `pos`.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-low reset. Assertion is immediate; release is synchronous to `clk`.
- `en` input 1: advance one step on this edge.
- `dir` input 1: 0 = shift toward MSB (left); 1 = shift toward LSB (right).
- `mode` input 1: 0 = one-hot ring; 1 = Johnson (twisted ring).
- `load` input 1: parallel load of `load_val` on this edge.
- `load_val` input WIDTH: pattern to load.
- `out` output WIDTH: current ring state (registered).
- `pos` output POS_W: sequence index of `out` (registered).
- `wrap` output 1: one-cycle pulse while `out` has just stepped back to the mode seed (registered).
- `legal` output 1: combinational decode; 1 when `out` is a member of the current mode's sequence.

## Operation
- Seeds: ring = `{WIDTH-1{0},1}`; Johnson = all zeros. The period P is WIDTH in ring mode and 2*WIDTH in Johnson mode.
- Ring step: left is `{out[W-2:0], out[W-1]}`; right is `{out[0], out[W-1:1]}`.
- Johnson step: left is `{out[W-2:0], ~out[W-1]}`; right is `{~out[0], out[W-1:1]}`.
- `pos` update: a left step increments `pos` mod P; a right step decrements `pos` mod P (0 → P-1).
- Left sequence from the seed defines `pos`:
  - Ring: `pos` = index of the set bit.
  - Johnson: `pos` = k (1..W) for k ones in the LSBs. `pos` = W+j (1..W-1) for ones in the top W-j bits and zeros in the low j bits.
- Internal `mode_q` register holds the last accepted mode.
- Edge priority, highest first:
  1. Reset.
  2. Mode change (`mode != mode_q`): `out` ← seed of the new mode, `pos` ← 0, `mode_q` ← `mode`, `wrap` ← 0. `load` and `en` are ignored on that edge.
  3. `load`: `out` ← `load_val`. `pos` ← decoded position if `load_val` is legal, else `pos` holds. `wrap` ← 0.
  4. `en`: one step per the rules above and per Configuration. `wrap` ← 1 iff the step produces `pos` = 0.
  5. Otherwise everything holds and `wrap` ← 0.
- While `legal` = 0, `pos` is don't-care and holds. An illegal pattern never sets `wrap`.

## Timing
- Reset values: `out` = `{WIDTH-1{0},1}`, `pos` = 0, `wrap` = 0, `mode_q` = 0. `legal` = 1 after reset.
- If `mode` = 1 at reset release, the first edge performs the mode reload to all zeros. `en` is ignored on that edge.
- All actions take one-cycle latency: edge n inputs are visible on outputs after edge n.
- `legal` has zero latency relative to `out` and reflects the current `mode_q`.
- `wrap` is high for exactly one cycle per seed return, including in consecutive periods with `en` held high.
- Reset asserted mid-sequence forces the reset values immediately, independent of `clk`.

## Configuration
- Macro: `RING_SELF_CORRECT_EN`.
- Defined: an `en` edge taken while `legal` = 0 reloads the current mode seed and sets `pos` ← 0 and `wrap` ← 0, instead of shifting. An illegal `load` is therefore cleared on the next enabled step.
- Undefined: an illegal pattern shifts with the normal rule and `pos` holds. `legal` stays 0 until a load, mode change or reset.

## Test plan
- WIDTH=4, reset, mode=0, dir=0, en=1 → `out` 0001, 0010, 0100, 1000, 0001. `pos` 0,1,2,3,0. `wrap` high only in the cycle `out` returns to 0001.
- mode 0→1, en=1 → next edge `out`=0000 with `pos`=0, then 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000. `wrap`=1 at the final 0000 (`pos` 0).
- Ring at 0001, dir=1, en=1 → `out`=1000, `pos`=3, no `wrap`. The next step gives 0100 with `pos`=2.
- Ring, load=1, load_val=0101 → `legal`=0, `pos` holds.
  - Next en edge with `RING_SELF_CORRECT_EN` defined: `out`=0001, `pos`=0.
  - Without the macro: `out`=1010, `legal`=0.
- load=1 and en=1 on the same edge with load_val=0100 (ring) → `out`=0100, `pos`=2, no shift. Holding en=0 keeps `out` stable for 5 cycles.
- Johnson at 0111, rst pulled low between edges → `out`=0001, `pos`=0, `wrap`=0 immediately. After release with mode=1, the first edge gives `out`=0000.

Source files
------------

// File: rtl/ring_counter_gen.sv
// ring_counter_gen: parametrised one-hot / Johnson ring sequencer with direction, enable,
// parallel load, position index, wrap pulse and legality decode.
// Optional feature macro: RING_SELF_CORRECT_EN (an enabled step taken while the pattern is
// illegal reloads the mode seed instead of shifting).
module ring_counter_gen #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned POS_W = $clog2(2 * WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             mode_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] out_o,
    output logic [POS_W-1:0] pos_o,
    output logic             wrap_o,
    output logic             legal_o
);

    localparam logic [WIDTH-1:0] RingSeed = WIDTH'(1);
    localparam logic [WIDTH-1:0] JohnSeed = '0;
    localparam logic [POS_W-1:0] RingLast = POS_W'(WIDTH - 1);
    localparam logic [POS_W-1:0] JohnLast = POS_W'(2 * WIDTH - 1);

    logic [WIDTH-1:0] out_q, out_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             wrap_q, wrap_d;
    logic             mode_q, mode_d;

    logic [POS_W:0]   cur_dec;
    logic [POS_W:0]   ld_dec;
    logic             legal;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] seed;
    logic [POS_W-1:0] last;
    logic [POS_W-1:0] pos_step;

    // Returns {legal, pos} of pattern v within the sequence of mode m.
    function automatic logic [POS_W:0] decode(input logic [WIDTH-1:0] v, input logic m);
        logic [WIDTH-1:0] pat;
        logic [POS_W:0]   res;
        res = '0;
        pat = '0;
        if (!m) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                pat    = '0;
                pat[i] = 1'b1;
                if (v == pat) res = {1'b1, POS_W'(i)};
            end
        end else begin
            // First half: k ones filled in from the LSB.
            for (int k = 0; k <= int'(WIDTH); k++) begin
                for (int b = 0; b < int'(WIDTH); b++) pat[b] = (b < k);
                if (v == pat) res = {1'b1, POS_W'(k)};
            end
            // Second half: j zeros filled in from the LSB.
            for (int j = 1; j < int'(WIDTH); j++) begin
                for (int b = 0; b < int'(WIDTH); b++) pat[b] = (b >= j);
                if (v == pat) res = {1'b1, POS_W'(int'(WIDTH) + j)};
            end
        end
        return res;
    endfunction

    // Decode, single-step shift and next-state selection by edge priority.
    always_comb begin
        cur_dec = decode(out_q, mode_q);
        ld_dec  = decode(load_val_i, mode_q);
        legal   = cur_dec[POS_W];
        seed    = mode_q ? JohnSeed : RingSeed;
        last    = mode_q ? JohnLast : RingLast;

        unique case ({mode_q, dir_i})
            2'b00:   shifted = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
            2'b01:   shifted = {out_q[0], out_q[WIDTH-1:1]};
            2'b10:   shifted = {out_q[WIDTH-2:0], ~out_q[WIDTH-1]};
            default: shifted = {~out_q[0], out_q[WIDTH-1:1]};
        endcase

        if (dir_i) pos_step = (pos_q == '0) ? last : pos_q - POS_W'(1);
        else       pos_step = (pos_q == last) ? '0 : pos_q + POS_W'(1);

        out_d  = out_q;
        pos_d  = pos_q;
        mode_d = mode_q;
        wrap_d = 1'b0;

        if (mode_i != mode_q) begin
            mode_d = mode_i;
            out_d  = mode_i ? JohnSeed : RingSeed;
            pos_d  = '0;
        end else if (load_i) begin
            out_d = load_val_i;
            if (ld_dec[POS_W]) pos_d = ld_dec[POS_W-1:0];
        end else if (en_i) begin
`ifdef RING_SELF_CORRECT_EN
            if (!legal) begin
                out_d = seed;
                pos_d = '0;
            end else begin
                out_d  = shifted;
                pos_d  = pos_step;
                wrap_d = (pos_step == '0);
            end
`else
            out_d = shifted;
            // Position is meaningless for an illegal pattern, so it holds and never wraps.
            if (legal) begin
                pos_d  = pos_step;
                wrap_d = (pos_step == '0);
            end
`endif
        end
    end

    // State registers; reset forces the ring seed immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q  <= RingSeed;
            pos_q  <= '0;
            wrap_q <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            pos_q  <= pos_d;
            wrap_q <= wrap_d;
            mode_q <= mode_d;
        end
    end

    assign out_o   = out_q;
    assign pos_o   = pos_q;
    assign wrap_o  = wrap_q;
    assign legal_o = legal;

endmodule

// File: tb/tb_ring_counter_gen.sv
// Directed bench for ring_counter_gen (WIDTH=4), with expectations for both builds of
// RING_SELF_CORRECT_EN.
module tb_ring_counter_gen;

    localparam int unsigned W  = 4;
    localparam int unsigned PW = 3;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          dir;
    logic          mode;
    logic          load;
    logic [W-1:0]  load_val;
    logic [W-1:0]  out;
    logic [PW-1:0] pos;
    logic          wrap;
    logic          legal;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] ring_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] john_exp [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                 4'b1110, 4'b1100, 4'b1000, 4'b0000};

    ring_counter_gen #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .dir_i      (dir),
        .mode_i     (mode),
        .load_i     (load),
        .load_val_i (load_val),
        .out_o      (out),
        .pos_o      (pos),
        .wrap_o     (wrap),
        .legal_o    (legal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [3:0] e_out, input logic [2:0] e_pos,
                             input logic e_wrap, input logic e_legal);
        chk({tag, ".out"}, 32'(out), 32'(e_out));
        chk({tag, ".pos"}, 32'(pos), 32'(e_pos));
        chk({tag, ".wrap"}, 32'(wrap), 32'(e_wrap));
        chk({tag, ".legal"}, 32'(legal), 32'(e_legal));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = '0;
        #12;
        chk_state("reset", 4'b0001, 3'd0, 1'b0, 1'b1);
        rst_n = 1'b1;

        // Ring, left, full period plus one step.
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_state($sformatf("ring_left%0d", i), ring_exp[i], 3'((i + 1) % 4), i == 3, 1'b1);
        end
        step();
        chk_state("ring_left_after_wrap", 4'b0010, 3'd1, 1'b0, 1'b1);

        // Ring, right: 0010 -> 0001 (wrap) -> 1000 -> 0100.
        dir = 1'b1;
        step();
        chk_state("ring_right0", 4'b0001, 3'd0, 1'b1, 1'b1);
        step();
        chk_state("ring_right1", 4'b1000, 3'd3, 1'b0, 1'b1);
        step();
        chk_state("ring_right2", 4'b0100, 3'd2, 1'b0, 1'b1);

        // Load beats enable on the same edge; then hold with en low.
        dir = 1'b0; load = 1'b1; load_val = 4'b0100;
        step();
        chk_state("load_with_en", 4'b0100, 3'd2, 1'b0, 1'b1);
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_state($sformatf("hold%0d", i), 4'b0100, 3'd2, 1'b0, 1'b1);
        end

        // Illegal load; pos holds.
        load = 1'b1; load_val = 4'b0101;
        step();
        chk_state("illegal_load", 4'b0101, 3'd2, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        step();
`ifdef RING_SELF_CORRECT_EN
        chk_state("illegal_step", 4'b0001, 3'd0, 1'b0, 1'b1);
`else
        chk_state("illegal_step", 4'b1010, 3'd2, 1'b0, 1'b0);
`endif
        en = 1'b0; load = 1'b1; load_val = 4'b0001;
        step();
        chk_state("reload_seed", 4'b0001, 3'd0, 1'b0, 1'b1);
        load = 1'b0;

        // Mode change to Johnson ignores en, then a full period.
        mode = 1'b1; en = 1'b1;
        step();
        chk_state("mode_change", 4'b0000, 3'd0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk_state($sformatf("john_left%0d", i), john_exp[i], 3'((i + 1) % 8), i == 7, 1'b1);
        end

        // Johnson right from seed, then back left to seed.
        dir = 1'b1;
        step();
        chk_state("john_right", 4'b1000, 3'd7, 1'b0, 1'b1);
        dir = 1'b0;
        step();
        chk_state("john_back", 4'b0000, 3'd0, 1'b1, 1'b1);

        // Illegal Johnson pattern decode.
        en = 1'b0; load = 1'b1; load_val = 4'b0101;
        step();
        chk("john_illegal.legal", 32'(legal), 32'd0);
        load_val = 4'b0000;
        step();
        chk_state("john_reload", 4'b0000, 3'd0, 1'b0, 1'b1);
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk_state("john_0111", 4'b0111, 3'd3, 1'b0, 1'b1);

        // Asynchronous reset mid-cycle, release with mode still 1.
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("async_reset", 4'b0001, 3'd0, 1'b0, 1'b1);
        #3;
        rst_n = 1'b1;
        step();
        chk_state("post_reset_reload", 4'b0000, 3'd0, 1'b0, 1'b1);
        step();
        chk_state("post_reset_step", 4'b0001, 3'd1, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
